calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1023, maximum cycles spent in WAIT before abort; valid range 1..65535.
REQ-002 Parameter: RES_ADDR, 2, BRAM word address of the result; operand A uses address 0, operand B uses address 1.
REQ-003 Port: clk  input  1  system clock, 100 MHz.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: commit  input  1  single-cycle pulse, synchronous to clk, requesting storage of operand.
REQ-006 Port: operand  input  16  two's-complement operand value, range -999..999.
REQ-007 Port: slot  input  1  target operand; 0 = A, 1 = B.
REQ-008 Port: op  input  3  ALU opcode.
REQ-009 Port: alu_done  input  1  ALU completion pulse; alu_result and alu_error are valid in the same cycle.
REQ-010 Port: alu_result  input  16  ALU result.
REQ-011 Port: alu_error  input  1  ALU error flag.
REQ-012 Port: bram_we  output  1  BRAM write enable, one cycle per write.
REQ-013 Port: bram_addr  output  2  BRAM word address.
REQ-014 Port: bram_din  output  16  BRAM write data.
REQ-015 Port: alu_start  output  1  one-cycle ALU start pulse.
REQ-016 Port: alu_a, alu_b  output  16 each  latched operands.
REQ-017 Port: alu_op  output  3  latched opcode.
REQ-018 Port: busy  output  1  high in every state except IDLE.
REQ-019 Port: a_loaded, b_loaded  output  1 each  operand-present flags.
REQ-020 Port: result_valid  output  1  result written and stable.
REQ-021 Port: error  output  1  last operation failed (ALU error or timeout).

Function
REQ-022 FSM states SHALL be IDLE, WR_OPND, START, WAIT, WR_RES and DONE; all outputs are registered.
REQ-023 IDLE + commit: latch operand into A (slot=0) or B (slot=1); next state WR_OPND; clear result_valid and error.
REQ-024 WR_OPND: bram_we=1, bram_addr=slot (0 or 1), bram_din=latched operand for exactly one cycle; set the matching loaded flag; return to IDLE; commit-to-bram_we latency is 1 cycle.
REQ-025 Committing an already-loaded slot SHALL overwrite the stored value and rewrite BRAM.
REQ-026 IDLE with a_loaded=1, b_loaded=1 and commit=0: latch op into alu_op; next state START.
REQ-027 In IDLE, commit SHALL take priority over an operation launch.
REQ-028 START: assert alu_start for one cycle; alu_a, alu_b and alu_op stay stable from START until DONE; clear the timeout counter; next state WAIT.
REQ-029 WAIT: a 16-bit counter increments each cycle.
  - alu_done: capture alu_result and alu_error.
  - Counter reaching TIMEOUT_CYCLES without alu_done: capture 16'h8000 and error=1.
  - Either event: next state WR_RES.
REQ-030 alu_done and timeout in the same cycle: alu_done wins.
REQ-031 WR_RES: bram_we=1, bram_addr=RES_ADDR, bram_din=captured value, for one cycle; next state DONE.
REQ-032 DONE: set result_valid and error=captured error; clear both loaded flags; next state IDLE.
REQ-033 result_valid and error SHALL hold until the next accepted commit.
REQ-034 A commit in any state other than IDLE SHALL be ignored and not queued.
REQ-035 alu_done outside WAIT SHALL be ignored.

Reset
REQ-036 Reset SHALL force IDLE at any time, including mid-WAIT or mid-write.
REQ-037 Reset SHALL drive every output to 0: bram_we, bram_addr, bram_din, alu_start, alu_a, alu_b, alu_op, busy, a_loaded, b_loaded, result_valid, error.
REQ-038 Reset SHALL clear the timeout counter.
REQ-039 BRAM contents are not touched by reset.
REQ-040 The first commit after reset release SHALL be accepted normally.

Verification
REQ-041 Normal flow: commit slot=0 operand=123 -> bram_we at addr 0 with din 123 one cycle later. Then commit slot=1 operand=-45 (16'hFFD3) -> write at addr 1. Then alu_start pulses once with alu_a=123 and alu_b=-45.
REQ-042 Completion: alu_done with alu_result=78 three cycles after alu_start -> write at addr 2 with din 78, then result_valid=1, error=0, busy=0, both loaded flags=0.
REQ-043 Timeout: TIMEOUT_CYCLES=8 and alu_done never asserted -> write at addr 2 with din 16'h8000, error=1, return to IDLE.
REQ-044 Overwrite and ignore: commit slot=0 with 5 then with 7 -> two writes at addr 0, alu_a=7. A commit during WAIT -> no BRAM write and loaded flags unchanged.
REQ-045 Reset during WAIT -> all outputs 0 immediately. A later alu_done pulse -> no write and no state change.
REQ-046 Simultaneous events: alu_done coincides with timeout -> alu_result written and error=alu_error. A commit in the cycle both flags become set -> commit served first, then the operation starts.

Source files
------------

// File: rtl/calc_sequencer.sv
// Sequencer that stores two operands into BRAM, runs one ALU operation on them,
// and writes the result (or a timeout code) back to BRAM.
module calc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned RES_ADDR       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [15:0] operand,
    input  logic        slot,
    input  logic [2:0]  op,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic        alu_error,
    output logic        bram_we,
    output logic [1:0]  bram_addr,
    output logic [15:0] bram_din,
    output logic        alu_start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        busy,
    output logic        a_loaded,
    output logic        b_loaded,
    output logic        result_valid,
    output logic        error
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  RES_WORD     = 2'(RES_ADDR);
    localparam logic [15:0] TIMEOUT_CODE = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        WR_OPND,
        START,
        WAIT,
        WR_RES,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic        err_cap;

    // Outputs are updated on the edge that enters the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 16'd0;
            err_cap      <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= 2'd0;
            bram_din     <= 16'd0;
            alu_start    <= 1'b0;
            alu_a        <= 16'd0;
            alu_b        <= 16'd0;
            alu_op       <= 3'd0;
            busy         <= 1'b0;
            a_loaded     <= 1'b0;
            b_loaded     <= 1'b0;
            result_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            bram_we   <= 1'b0;
            alu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit) begin
                        if (slot) alu_b <= operand;
                        else      alu_a <= operand;
                        bram_we      <= 1'b1;
                        bram_addr    <= {1'b0, slot};
                        bram_din     <= operand;
                        result_valid <= 1'b0;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        state        <= WR_OPND;
                    end else if (a_loaded && b_loaded) begin
                        alu_op    <= op;
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                WR_OPND: begin
                    // bram_addr[0] still holds the slot of the write just issued
                    if (bram_addr[0]) b_loaded <= 1'b1;
                    else              a_loaded <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                START: begin
                    count <= 16'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    count <= count + 16'd1;
                    if (alu_done) begin
                        bram_we   <= 1'b1;
                        bram_addr <= RES_WORD;
                        bram_din  <= alu_result;
                        err_cap   <= alu_error;
                        state     <= WR_RES;
                    end else if (count == TIMEOUT_LAST) begin
                        bram_we   <= 1'b1;
                        bram_addr <= RES_WORD;
                        bram_din  <= TIMEOUT_CODE;
                        err_cap   <= 1'b1;
                        state     <= WR_RES;
                    end
                end
                WR_RES: begin
                    state <= DONE;
                end
                DONE: begin
                    result_valid <= 1'b1;
                    error        <= err_cap;
                    a_loaded     <= 1'b0;
                    b_loaded     <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected BRAM writes,
// ALU launches and completion status; a negedge monitor pops and compares.
module tb_calc_sequencer;

    localparam int unsigned T   = 8;
    localparam int unsigned RES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit;
    logic [15:0] operand;
    logic        slot;
    logic [2:0]  op;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_error;
    logic        bram_we;
    logic [1:0]  bram_addr;
    logic [15:0] bram_din;
    logic        alu_start;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_op;
    logic        busy;
    logic        a_loaded;
    logic        b_loaded;
    logic        result_valid;
    logic        error;

    calc_sequencer #(.TIMEOUT_CYCLES(T), .RES_ADDR(RES)) dut (
        .clk(clk), .reset(reset), .commit(commit), .operand(operand),
        .slot(slot), .op(op), .alu_done(alu_done), .alu_result(alu_result),
        .alu_error(alu_error), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .alu_start(alu_start), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .busy(busy), .a_loaded(a_loaded),
        .b_loaded(b_loaded), .result_valid(result_valid), .error(error)
    );

    always #5 clk = ~clk;

    logic [17:0] wr_q[$];
    logic [34:0] st_q[$];
    logic        done_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] ma, mb;
    bit          ma_ld, mb_ld;
    logic        rv_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [59:0] all_outs();
        return {bram_we, bram_addr, bram_din, alu_start, alu_a, alu_b, alu_op,
                busy, a_loaded, b_loaded, result_valid, error};
    endfunction

    // Monitor: every observed event must match the head of its queue.
    always @(negedge clk) begin
        logic [17:0] ew;
        logic [34:0] es;
        logic        ee;
        if (!reset) begin
            if (bram_we) begin
                if (wr_q.size() == 0) check("unexpected_write", {bram_addr, bram_din}, 64'd0);
                else begin
                    ew = wr_q.pop_front();
                    check("bram_write", {bram_addr, bram_din}, ew);
                end
            end
            if (alu_start) begin
                if (st_q.size() == 0) check("unexpected_start", {alu_a, alu_b, alu_op}, 64'd0);
                else begin
                    es = st_q.pop_front();
                    check("alu_launch", {alu_a, alu_b, alu_op}, es);
                end
            end
            if (result_valid && !rv_prev) begin
                if (done_q.size() == 0) check("unexpected_done", {error, busy}, 64'd0);
                else begin
                    ee = done_q.pop_front();
                    check("done_status", {error, busy, a_loaded, b_loaded}, {ee, 3'b000});
                end
            end
        end
        rv_prev = result_valid;
    end

    // Called right after a negedge while the DUT is idle; returns two negedges later.
    task automatic do_commit(input bit s, input logic [15:0] v);
        commit = 1'b1; slot = s; operand = v;
        wr_q.push_back({1'b0, s, v});
        if (s) begin mb = v; mb_ld = 1'b1; end
        else   begin ma = v; ma_ld = 1'b1; end
        @(negedge clk);
        commit = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = alu_start;
        end
        check("start_seen", seen, 1);
    endtask

    // Launch with both operands loaded; alu_done arrives in WAIT cycle k (k > T means timeout).
    task automatic run_op(input int k, input logic [15:0] res, input bit err, input bit inj);
        st_q.push_back({ma, mb, op});
        if (k <= int'(T)) begin
            wr_q.push_back({2'(RES), res});
            done_q.push_back(err);
        end else begin
            wr_q.push_back({2'(RES), 16'h8000});
            done_q.push_back(1'b1);
        end
        wait_start();
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            commit   = (j == 1) && inj;
            operand  = 16'h1234;
            alu_done = (j == k);
            if (j == k) begin alu_result = res; alu_error = err; end
            if (inj && j == 2) check("flags_in_wait", {a_loaded, b_loaded, busy}, 3'b111);
        end
        @(negedge clk);
        commit = 1'b0; alu_done = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("back_to_idle", {busy, result_valid, a_loaded, b_loaded}, 4'b0100);
        ma_ld = 1'b0; mb_ld = 1'b0;
    endtask

    task automatic reset_mid_wait();
        do_commit(1'b0, 16'd11);
        do_commit(1'b1, 16'd22);
        st_q.push_back({ma, mb, op});
        wait_start();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_wait", all_outs(), 60'd0);
        @(negedge clk);
        reset = 1'b0;
        ma_ld = 1'b0; mb_ld = 1'b0;
        @(negedge clk);
        alu_done = 1'b1; alu_result = 16'h5555; alu_error = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_ignored", all_outs(), 60'd0);
    endtask

    task automatic random_txn();
        int n = int'($urandom_range(4, 2));
        int i = 0;
        bit s;
        op = 3'($urandom);
        while (!(ma_ld && mb_ld) || i < n) begin
            s = 1'($urandom);
            if (i >= n - 1) begin
                if (!ma_ld) s = 1'b0;
                else if (!mb_ld) s = 1'b1;
            end
            do_commit(s, 16'(int'($urandom_range(1998, 0)) - 999));
            i++;
        end
        run_op(int'($urandom_range(T + 2, 1)), 16'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        reset = 1'b1; commit = 1'b0; operand = 16'd0; slot = 1'b0; op = 3'd0;
        alu_done = 1'b0; alu_result = 16'd0; alu_error = 1'b0;
        ma = 16'd0; mb = 16'd0; ma_ld = 1'b0; mb_ld = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outs(), 60'd0);
        reset = 1'b0;
        @(negedge clk);

        // Normal flow and completion
        op = 3'd5;
        do_commit(1'b0, 16'd123);
        do_commit(1'b1, 16'hFFD3);
        run_op(3, 16'd78, 1'b0, 1'b0);

        // Timeout with a late alu_done landing after the abort
        op = 3'd2;
        do_commit(1'b1, 16'd300);
        do_commit(1'b0, 16'hFC19);
        run_op(int'(T) + 1, 16'd0, 1'b0, 1'b0);

        // alu_done on the last allowed WAIT cycle wins over timeout
        op = 3'd7;
        do_commit(1'b0, 16'd1);
        do_commit(1'b1, 16'd2);
        run_op(int'(T), 16'h0ABC, 1'b1, 1'b0);

        // Overwrite slot A, extra commit when both are loaded, commit during WAIT
        op = 3'd1;
        do_commit(1'b0, 16'd5);
        do_commit(1'b0, 16'd7);
        do_commit(1'b1, 16'd9);
        do_commit(1'b1, 16'd10);
        run_op(2, 16'd17, 1'b0, 1'b1);

        reset_mid_wait();

        for (int t = 0; t < 30; t++) random_txn();

        repeat (4) @(negedge clk);
        check("queues_drained", {32'(wr_q.size()), 16'(st_q.size()), 16'(done_q.size())}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
